// File: rtl/arm_shift_unit.sv
// arm_shift_unit: registered ARM operand-2 barrel shifter (LSL/LSR/ASR/ROR/RRX) with 1-cycle latency.
// Optional macro SHIFTER_RRX_EN: immediate ROR #0 decodes to RRX (op 100); undefined removes RRX.
module arm_shift_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] Instr,
  input  logic        rot_imm,
  input  logic        Rs_in,
  input  logic [31:0] shift_in,
  input  logic [5:0]  shift_val,
  input  logic        carry_flag,
  input  logic        in_valid,
  output logic [2:0]  op,
  output logic        src,
  output logic [31:0] shifter_operand,
  output logic        shifter_carry,
  output logic        out_valid
);

  typedef enum logic [2:0] {
    OP_LSL = 3'b000,
    OP_LSR = 3'b001,
    OP_ASR = 3'b010,
    OP_ROR = 3'b011,
    OP_RRX = 3'b100
  } shift_op_t;

  shift_op_t   op_d;
  logic        src_d;
  logic [5:0]  amt;
  logic [4:0]  amt_lo;
  logic [4:0]  lsl_idx;
  logic [4:0]  rsh_idx;
  logic [31:0] rot_res;
  logic [31:0] res_d;
  logic        carry_d;
  logic        unused_instr_bits;

  // The amount always arrives on shift_val from the upstream mux.
  assign unused_instr_bits = ^{Instr[11:7], Instr[3:0]};

  always_comb begin
    src_d = 1'b0;
    op_d  = OP_ROR;
    if (!rot_imm) begin
      src_d = Instr[4] & ~Rs_in;
      op_d  = shift_op_t'({1'b0, Instr[6:5]});
`ifdef SHIFTER_RRX_EN
      if (!src_d && shift_val == 6'd0 && Instr[6:5] == 2'b11)
        op_d = OP_RRX;
`endif
    end
  end

  // Immediate LSR/ASR #0 encode a shift by 32.
  always_comb begin
    amt = shift_val;
    if (!rot_imm && !src_d && shift_val == 6'd0 && (op_d == OP_LSR || op_d == OP_ASR))
      amt = 6'd32;
  end

  assign amt_lo  = amt[4:0];
  assign lsl_idx = 5'd0 - amt_lo;
  assign rsh_idx = amt_lo - 5'd1;
  assign rot_res = (shift_in >> amt_lo) | (shift_in << lsl_idx);

  always_comb begin
    res_d   = shift_in;
    carry_d = carry_flag;
    case (op_d)
      OP_LSL: begin
        if (amt != 6'd0) begin
          if (!amt[5]) begin
            res_d   = shift_in << amt_lo;
            carry_d = shift_in[lsl_idx];
          end else begin
            res_d   = '0;
            carry_d = (amt == 6'd32) ? shift_in[0] : 1'b0;
          end
        end
      end
      OP_LSR: begin
        if (amt != 6'd0) begin
          if (!amt[5]) begin
            res_d   = shift_in >> amt_lo;
            carry_d = shift_in[rsh_idx];
          end else begin
            res_d   = '0;
            carry_d = (amt == 6'd32) ? shift_in[31] : 1'b0;
          end
        end
      end
      OP_ASR: begin
        if (amt != 6'd0) begin
          if (!amt[5]) begin
            res_d   = $signed(shift_in) >>> amt_lo;
            carry_d = shift_in[rsh_idx];
          end else begin
            res_d   = {32{shift_in[31]}};
            carry_d = shift_in[31];
          end
        end
      end
      // Rotation carry is always the new bit 31, which also covers multiples of 32.
      OP_ROR: begin
        if (amt != 6'd0) begin
          res_d   = rot_res;
          carry_d = rot_res[31];
        end
      end
`ifdef SHIFTER_RRX_EN
      OP_RRX: begin
        res_d   = {carry_flag, shift_in[31:1]};
        carry_d = shift_in[0];
      end
`endif
      default: begin
        res_d   = shift_in;
        carry_d = carry_flag;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op              <= 3'b000;
      src             <= 1'b0;
      shifter_operand <= '0;
      shifter_carry   <= 1'b0;
      out_valid       <= 1'b0;
    end else begin
      op              <= op_d;
      src             <= src_d;
      shifter_operand <= res_d;
      shifter_carry   <= carry_d;
      out_valid       <= in_valid;
    end
  end

endmodule

// File: tb/tb_arm_shift_unit.sv
// tb_arm_shift_unit: scoreboard bench for arm_shift_unit using a bit-serial reference model.
// Honours SHIFTER_RRX_EN the same way as the design.
module tb_arm_shift_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] Instr;
  logic        rot_imm;
  logic        Rs_in;
  logic [31:0] shift_in;
  logic [5:0]  shift_val;
  logic        carry_flag;
  logic        in_valid;
  logic [2:0]  op;
  logic        src;
  logic [31:0] shifter_operand;
  logic        shifter_carry;
  logic        out_valid;

  typedef struct packed {
    logic [2:0]  op;
    logic        src;
    logic [31:0] res;
    logic        cy;
    logic        v;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  arm_shift_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .Instr           (Instr),
    .rot_imm         (rot_imm),
    .Rs_in           (Rs_in),
    .shift_in        (shift_in),
    .shift_val       (shift_val),
    .carry_flag      (carry_flag),
    .in_valid        (in_valid),
    .op              (op),
    .src             (src),
    .shifter_operand (shifter_operand),
    .shifter_carry   (shifter_carry),
    .out_valid       (out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: shifts one bit at a time, letting carry fall out naturally.
  function automatic exp_t model(input logic [11:0] ins, input logic rot, input logic rs,
                                 input logic [31:0] x, input logic [5:0] n, input logic c,
                                 input logic v);
    exp_t e;
    int   cnt;
    logic [31:0] r;
    logic        cy;
    r   = x;
    cy  = c;
    cnt = int'(n);
    e.src = rot ? 1'b0 : (ins[4] & ~rs);
    if (rot) begin
      e.op = 3'b011;
    end else begin
      e.op = {1'b0, ins[6:5]};
      if (!e.src && n == 6'd0) begin
        if (ins[6:5] == 2'b01 || ins[6:5] == 2'b10) cnt = 32;
`ifdef SHIFTER_RRX_EN
        if (ins[6:5] == 2'b11) e.op = 3'b100;
`endif
      end
    end
    case (e.op)
      3'b000: for (int i = 0; i < cnt; i++) begin cy = r[31]; r = {r[30:0], 1'b0}; end
      3'b001: for (int i = 0; i < cnt; i++) begin cy = r[0]; r = {1'b0, r[31:1]}; end
      3'b010: for (int i = 0; i < cnt; i++) begin cy = r[0]; r = {r[31], r[31:1]}; end
      3'b011: begin
        for (int i = 0; i < cnt; i++) r = {r[0], r[31:1]};
        if (cnt != 0) cy = r[31];
      end
      3'b100: begin r = {c, x[31:1]}; cy = x[0]; end
      default: ;
    endcase
    e.res = r;
    e.cy  = cy;
    e.v   = v;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic popAndCompare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, ".op"},    32'(op),              32'(e.op));
      checkOutput({tag, ".src"},   32'(src),             32'(e.src));
      checkOutput({tag, ".res"},   shifter_operand,      e.res);
      checkOutput({tag, ".carry"}, 32'(shifter_carry),   32'(e.cy));
      checkOutput({tag, ".valid"}, 32'(out_valid),       32'(e.v));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [11:0] ins, input logic rot,
                               input logic rs, input logic [31:0] x, input logic [5:0] n,
                               input logic c, input logic v);
    @(negedge clk);
    Instr      = ins;
    rot_imm    = rot;
    Rs_in      = rs;
    shift_in   = x;
    shift_val  = n;
    carry_flag = c;
    in_valid   = v;
    sb_q.push_back(model(ins, rot, rs, x, n, c, v));
    @(posedge clk);
    #1;
    popAndCompare(tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".op"},    32'(op),            32'd0);
    checkOutput({tag, ".src"},   32'(src),           32'd0);
    checkOutput({tag, ".res"},   shifter_operand,    32'd0);
    checkOutput({tag, ".carry"}, 32'(shifter_carry), 32'd0);
    checkOutput({tag, ".valid"}, 32'(out_valid),     32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] special [8];
    special = '{6'd0, 6'd1, 6'd31, 6'd32, 6'd33, 6'd40, 6'd63, 6'd16};

    reset_n    = 1'b1;
    Instr      = '0;
    rot_imm    = 1'b0;
    Rs_in      = 1'b0;
    shift_in   = '0;
    shift_val  = '0;
    carry_flag = 1'b0;
    in_valid   = 1'b0;
    #1 reset_n = 1'b0;
    #1 checkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors, including the documented examples.
    applyStimulus("imm_lsl4",   12'h200, 1'b0, 1'b0, 32'h1000_0001, 6'd4,  1'b0, 1'b1);
    checkOutput("imm_lsl4.const", shifter_operand, 32'h0000_0010);
    applyStimulus("imm_lsr0",   12'h020, 1'b0, 1'b0, 32'h8000_0000, 6'd0,  1'b0, 1'b1);
    applyStimulus("reg_asr40",  12'h050, 1'b0, 1'b0, 32'h8000_0000, 6'd40, 1'b0, 1'b1);
    checkOutput("reg_asr40.const", shifter_operand, 32'hFFFF_FFFF);
    applyStimulus("rot_imm",    12'h000, 1'b1, 1'b0, 32'h0000_0003, 6'd2,  1'b0, 1'b1);
    checkOutput("rot_imm.const", shifter_operand, 32'hC000_0000);
    applyStimulus("rrx",        12'h060, 1'b0, 1'b0, 32'h0000_0003, 6'd0,  1'b1, 1'b1);
    applyStimulus("imm_lsl0",   12'h000, 1'b0, 1'b0, 32'hDEAD_BEEF, 6'd0,  1'b1, 1'b1);
    applyStimulus("imm_asr0",   12'h040, 1'b0, 1'b0, 32'h7000_0000, 6'd0,  1'b1, 1'b1);
    applyStimulus("reg_lsl32",  12'h010, 1'b0, 1'b0, 32'h0000_0001, 6'd32, 1'b0, 1'b1);
    applyStimulus("reg_lsl33",  12'h010, 1'b0, 1'b0, 32'hFFFF_FFFF, 6'd33, 1'b1, 1'b1);
    applyStimulus("reg_lsr32",  12'h030, 1'b0, 1'b0, 32'h8000_0000, 6'd32, 1'b0, 1'b1);
    applyStimulus("reg_lsr1",   12'h030, 1'b0, 1'b0, 32'h0000_0003, 6'd1,  1'b0, 1'b1);
    applyStimulus("reg_ror32",  12'h070, 1'b0, 1'b0, 32'h8000_0001, 6'd32, 1'b0, 1'b1);
    applyStimulus("reg_ror0",   12'h070, 1'b0, 1'b0, 32'h8000_0001, 6'd0,  1'b1, 1'b1);
    applyStimulus("reg_ror8",   12'h070, 1'b0, 1'b0, 32'h1234_5678, 6'd8,  1'b0, 1'b1);
    applyStimulus("mem_rs_in",  12'h010, 1'b0, 1'b1, 32'h0000_0001, 6'd3,  1'b0, 1'b1);
    applyStimulus("rot_imm0",   12'h000, 1'b1, 1'b0, 32'h0000_00FF, 6'd0,  1'b1, 1'b1);
    applyStimulus("invalid",    12'h200, 1'b0, 1'b0, 32'h0000_0001, 6'd1,  1'b0, 1'b0);

    // Register sweep across the amount boundaries for each shift type.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 8; k++) begin
        logic [11:0] ins;
        ins = 12'h010 | (12'(t) << 5);
        applyStimulus("sweep", ins, 1'b0, 1'b0, 32'h8000_0001 ^ (32'h0F0F_0F0F << t),
                      special[k], k[0], 1'b1);
      end
    end

    // Random mix of all forms.
    for (int k = 0; k < 250; k++) begin
      logic [5:0] n;
      n = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
      applyStimulus("random", 12'($urandom_range(0, 4095)), ($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 1)), $urandom, n, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end

    // Asynchronous reset between edges discards the in-flight result.
    applyStimulus("pre_reset", 12'h200, 1'b0, 1'b0, 32'h1000_0001, 6'd4, 1'b1, 1'b1);
    #3 reset_n = 1'b0;
    #1 checkAllZero("async_reset");
    @(posedge clk);
    #1 checkAllZero("reset_held");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("post_reset", 12'h050, 1'b0, 1'b0, 32'h8000_0000, 6'd40, 1'b0, 1'b1);

    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
